// File: rtl/fec_pingpong_scheduler_pkg.sv
// Shared definitions for the FEC ping-pong bit RAM scheduler.
//   BLOCK_BITS : bits per FEC block (one RAM bank)
//   TAIL_BITS  : tail-biting preload length (last TAIL_BITS bits of a block)
//   ADDR_W     : RAM address width, 2*BLOCK_BITS must fit in 2**ADDR_W
//   rd_state_t : read sequencer states
//   rd_flags_t : per-read sideband carried alongside the RAM read latency
package fec_pkg;

    localparam int unsigned BLOCK_BITS = 96;
    localparam int unsigned TAIL_BITS  = 6;
    localparam int unsigned ADDR_W     = 8;

    typedef enum logic [1:0] {
        R_IDLE,
        R_PRELOAD,
        R_STREAM
    } rd_state_t;

    typedef struct packed {
        logic valid;
        logic preload;
        logic first;
        logic last;
    } rd_flags_t;

    // Bank b occupies addresses [b*BLOCK_BITS, (b+1)*BLOCK_BITS).
    function automatic logic [ADDR_W-1:0] bank_base(input logic bank);
        return bank ? ADDR_W'(BLOCK_BITS) : '0;
    endfunction

endpackage

// File: rtl/fec_pingpong_scheduler_flag_pipe.sv
// Delays the read sideband flags by the RAM read latency so they line up with q_b.
//   clk_50, reset (async, active-high), flush (sync clear)
//   i_flags : {rd_en, preload, first, last} for the read issued this cycle
//   o_flags : the same flags RAM_LATENCY cycles later
module fec_rd_flag_pipe
    import fec_pkg::*;
#(
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic      clk_50,
    input  logic      reset,
    input  logic      flush,
    input  rd_flags_t i_flags,
    output rd_flags_t o_flags
);

    rd_flags_t r_pipe [RAM_LATENCY];

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < RAM_LATENCY; i++) r_pipe[i] <= '0;
        end else if (flush) begin
            // Reads in flight are discarded so nothing surfaces after a flush.
            for (int unsigned i = 0; i < RAM_LATENCY; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_flags;
            for (int unsigned i = 1; i < RAM_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_flags = r_pipe[RAM_LATENCY-1];

endmodule

// File: rtl/fec_pingpong_scheduler.sv
// Ping-pong bank scheduler for the tail-biting convolutional encoder bit RAM.
// Writes serial bits into the free bank; replays each full bank as TAIL_BITS
// preload reads followed by BLOCK_BITS stream reads.
//   clk_50, reset (async, active-high), flush (sync abandon of both banks)
//   wr_valid/wr_ready/wr_en/wr_addr : RAM port A write side
//   rd_ready/rd_en/rd_addr          : RAM port B read side
//   q_valid/q_preload/q_first/q_last: flags aligned with RAM q_b
//   bank_full                       : per-bank occupancy
//   blocks_done                     : wrapping count of fully streamed blocks
module fec_pingpong_scheduler
    import fec_pkg::*;
#(
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              flush,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              rd_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              q_valid,
    output logic              q_preload,
    output logic              q_first,
    output logic              q_last,
    output logic [1:0]        bank_full,
    output logic [15:0]       blocks_done
);

    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(BLOCK_BITS - 1);
    localparam logic [ADDR_W-1:0] CNT_PRE  = ADDR_W'(BLOCK_BITS - TAIL_BITS);

    rd_state_t         r_rd_state;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [1:0]        r_bank_full;
    logic [15:0]       r_blocks_done;

    logic              w_wr_done;
    logic              w_rd_done;
    logic [1:0]        w_set;
    logic [1:0]        w_clr;
    rd_flags_t         w_flags;
    rd_flags_t         w_q_flags;

    assign wr_ready    = !r_bank_full[r_wr_bank];
    assign wr_en       = wr_valid & wr_ready;
    assign wr_addr     = bank_base(r_wr_bank) + r_wr_cnt;
    assign rd_en       = (r_rd_state != R_IDLE) & rd_ready;
    assign rd_addr     = bank_base(r_rd_bank) + r_rd_cnt;
    assign bank_full   = r_bank_full;
    assign blocks_done = r_blocks_done;

    assign w_wr_done = wr_en && (r_wr_cnt == CNT_LAST);
    assign w_rd_done = rd_en && (r_rd_state == R_STREAM) && (r_rd_cnt == CNT_LAST);
    // Writer only targets an empty bank, so set and clear never hit the same bit.
    assign w_set = w_wr_done ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign w_clr = w_rd_done ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        w_flags         = '0;
        w_flags.valid   = rd_en;
        w_flags.preload = rd_en && (r_rd_state == R_PRELOAD);
        w_flags.first   = rd_en && (r_rd_state == R_STREAM) && (r_rd_cnt == '0);
        w_flags.last    = w_rd_done;
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_rd_state    <= R_IDLE;
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_wr_cnt      <= '0;
            r_rd_cnt      <= '0;
            r_bank_full   <= '0;
            r_blocks_done <= '0;
        end else if (flush) begin
            r_rd_state    <= R_IDLE;
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_wr_cnt      <= '0;
            r_rd_cnt      <= '0;
            r_bank_full   <= '0;
            r_blocks_done <= '0;
        end else begin
            if (wr_en) begin
                if (r_wr_cnt == CNT_LAST) begin
                    r_wr_cnt  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end

            r_bank_full <= (r_bank_full | w_set) & ~w_clr;

            case (r_rd_state)
                R_IDLE: begin
                    if (r_bank_full[r_rd_bank]) begin
                        r_rd_state <= R_PRELOAD;
                        r_rd_cnt   <= CNT_PRE;
                    end
                end
                R_PRELOAD: begin
                    if (rd_en) begin
                        if (r_rd_cnt == CNT_LAST) begin
                            r_rd_state <= R_STREAM;
                            r_rd_cnt   <= '0;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + 1'b1;
                        end
                    end
                end
                R_STREAM: begin
                    if (rd_en) begin
                        if (r_rd_cnt == CNT_LAST) begin
                            r_rd_state    <= R_IDLE;
                            r_rd_cnt      <= '0;
                            r_rd_bank     <= ~r_rd_bank;
                            r_blocks_done <= r_blocks_done + 16'd1;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + 1'b1;
                        end
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    fec_rd_flag_pipe #(
        .RAM_LATENCY(RAM_LATENCY)
    ) u_flag_pipe (
        .clk_50 (clk_50),
        .reset  (reset),
        .flush  (flush),
        .i_flags(w_flags),
        .o_flags(w_q_flags)
    );

    assign q_valid   = w_q_flags.valid;
    assign q_preload = w_q_flags.preload;
    assign q_first   = w_q_flags.first;
    assign q_last    = w_q_flags.last;

    always_ff @(posedge clk_50) begin
        if (!reset) begin
            assert (!(rd_en && !r_bank_full[r_rd_bank])) else $error("read issued on an empty bank");
            assert (!(wr_en && r_bank_full[r_wr_bank])) else $error("write issued to a full bank");
        end
    end

endmodule

// File: tb/tb_fec_pingpong_scheduler.sv
// Bench for fec_pingpong_scheduler: two instances (RAM latency 1 and 2) share
// one stimulus stream; a block-sequence model predicts every output each cycle.
module tb_fec_pingpong_scheduler;
    import fec_pkg::*;

    localparam int BB = BLOCK_BITS;
    localparam int TB = TAIL_BITS;

    logic clk_50 = 1'b0;
    logic reset = 1'b0, flush = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;

    logic              wr_ready1, wr_en1, rd_en1, q_valid1, q_preload1, q_first1, q_last1;
    logic [ADDR_W-1:0] wr_addr1, rd_addr1;
    logic [1:0]        bank_full1;
    logic [15:0]       blocks_done1;
    logic              wr_ready2, wr_en2, rd_en2, q_valid2, q_preload2, q_first2, q_last2;
    logic [ADDR_W-1:0] wr_addr2, rd_addr2;
    logic [1:0]        bank_full2;
    logic [15:0]       blocks_done2;

    always #10 clk_50 = ~clk_50;

    fec_pingpong_scheduler #(.RAM_LATENCY(1)) dut1 (
        .clk_50(clk_50), .reset(reset), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_en(wr_en1), .wr_addr(wr_addr1),
        .rd_ready(rd_ready), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .q_valid(q_valid1), .q_preload(q_preload1), .q_first(q_first1), .q_last(q_last1),
        .bank_full(bank_full1), .blocks_done(blocks_done1)
    );

    fec_pingpong_scheduler #(.RAM_LATENCY(2)) dut2 (
        .clk_50(clk_50), .reset(reset), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready2), .wr_en(wr_en2), .wr_addr(wr_addr2),
        .rd_ready(rd_ready), .rd_en(rd_en2), .rd_addr(rd_addr2),
        .q_valid(q_valid2), .q_preload(q_preload2), .q_first(q_first2), .q_last(q_last2),
        .bank_full(bank_full2), .blocks_done(blocks_done2)
    );

    function automatic logic [63:0] pack(input logic rdy, input logic wen, input logic [7:0] wa,
                                         input logic ren, input logic [7:0] ra, input logic [3:0] qf,
                                         input logic [1:0] bf, input logic [15:0] bd);
        return {23'd0, rdy, wen, wa, ren, ra, qf, bf, bd};
    endfunction

    logic [63:0] obs1, obs2;
    assign obs1 = pack(wr_ready1, wr_en1, wr_addr1, rd_en1, rd_addr1,
                       {q_valid1, q_preload1, q_first1, q_last1}, bank_full1, blocks_done1);
    assign obs2 = pack(wr_ready2, wr_en2, wr_addr2, rd_en2, rd_addr2,
                       {q_valid2, q_preload2, q_first2, q_last2}, bank_full2, blocks_done2);

    // Reference model: writer position, bank occupancy, and the reader as an
    // index into the 102-entry read sequence of the current bank (-1 = idle).
    int       m_wbank, m_wpos, m_rbank, m_ridx, m_done;
    bit [1:0] m_full;
    logic [3:0] m_hist [2];

    int n_cmp = 0, n_err = 0, cyc = 0;
    int c0, first1, first2, beats1, beats2, first_raddr;

    function automatic int seq_addr(input int bank, input int k);
        return bank * BB + ((k < TB) ? (BB - TB + k) : (k - TB));
    endfunction

    task automatic model_reset();
        m_wbank = 0; m_wpos = 0; m_rbank = 0; m_ridx = -1; m_done = 0;
        m_full = 2'b00; m_hist[0] = 4'h0; m_hist[1] = 4'h0;
    endtask

    function automatic logic [3:0] cur_flags(input logic rr);
        logic e;
        e = (m_ridx >= 0) && rr;
        return {e, e && (m_ridx < TB), e && (m_ridx == TB), e && (m_ridx == TB + BB - 1)};
    endfunction

    function automatic logic [63:0] expect_vec(input int lat);
        int raddr;
        raddr = (m_ridx < 0) ? m_rbank * BB : seq_addr(m_rbank, m_ridx);
        return pack(!m_full[m_wbank], wr_valid && !m_full[m_wbank], 8'(m_wbank * BB + m_wpos),
                    (m_ridx >= 0) && rd_ready, 8'(raddr), m_hist[lat - 1], m_full, 16'(m_done));
    endfunction

    task automatic model_update(input logic fl, input logic wv, input logic rr);
        int set_b, clr_b;
        if (fl) begin
            model_reset();
        end else begin
            m_hist[1] = m_hist[0];
            m_hist[0] = cur_flags(rr);
            set_b = -1; clr_b = -1;
            if (wv && !m_full[m_wbank]) begin
                m_wpos++;
                if (m_wpos == BB) begin m_wpos = 0; set_b = m_wbank; m_wbank ^= 1; end
            end
            if (m_ridx < 0) begin
                if (m_full[m_rbank]) m_ridx = 0;
            end else if (rr) begin
                m_ridx++;
                if (m_ridx == TB + BB) begin
                    clr_b = m_rbank; m_rbank ^= 1; m_done = (m_done + 1) % 65536; m_ridx = -1;
                end
            end
            if (set_b >= 0) m_full[set_b] = 1'b1;
            if (clr_b >= 0) m_full[clr_b] = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    task automatic track_reset();
        c0 = cyc; first1 = -1; first2 = -1; beats1 = 0; beats2 = 0; first_raddr = -1;
    endtask

    // Called at negedge with inputs already set for this cycle.
    task automatic step(input logic rst, input logic fl, input logic wv, input logic rr);
        reset = rst; flush = fl; wr_valid = wv; rd_ready = rr;
        if (rst) model_reset();
        #1;
        check("cyc_lat1", obs1, expect_vec(1));
        check("cyc_lat2", obs2, expect_vec(2));
        if (q_valid1) beats1++;
        if (q_valid2) beats2++;
        if (q_preload1 && first1 < 0) first1 = cyc - c0;
        if (q_preload2 && first2 < 0) first2 = cyc - c0;
        if (rd_en1 && first_raddr < 0) first_raddr = int'(rd_addr1);
        @(posedge clk_50);
        if (!rst) model_update(fl, wv, rr);
        @(negedge clk_50);
        cyc++;
    endtask

    initial begin
        int guard;
        logic rs, fl, wv, rr;
        model_reset();
        @(negedge clk_50);

        // Reset in the middle of a block write
        step(1, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 0, 1, 0);
        check("p1_wr_addr40", 64'(wr_addr1), 64'd40);
        step(1, 0, 0, 0);
        check("p1_rst_wr_ready", 64'(wr_ready1), 64'd1);
        check("p1_rst_bank_full", 64'(bank_full1), 64'd0);
        check("p1_rst_rd_en", 64'(rd_en1), 64'd0);
        check("p1_rst_wr_addr", 64'(wr_addr1), 64'd0);
        step(0, 0, 0, 0);

        // One block end to end
        track_reset();
        for (int i = 0; i < BB; i++) step(0, 0, 1, 1);
        guard = 0;
        while (blocks_done1 != 16'd1 && guard < 300) begin step(0, 0, 0, 1); guard++; end
        check("p2_blocks_done", 64'(blocks_done1), 64'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        check("p2_first_preload_lat1", 64'(first1), 64'd98);
        check("p2_first_preload_lat2", 64'(first2), 64'd99);
        check("p2_first_rd_addr", 64'(first_raddr), 64'd90);
        check("p2_beats_lat1", 64'(beats1), 64'd102);
        check("p2_beats_lat2", 64'(beats2), 64'd102);

        // Both banks fill while the reader is stalled
        for (int i = 0; i < 2 * BB; i++) step(0, 0, 1, 0);
        check("p3_bank_full", 64'(bank_full1), 64'd3);
        check("p3_wr_ready_low", 64'(wr_ready1), 64'd0);
        step(0, 0, 1, 0);
        guard = 0;
        while (blocks_done1 != 16'd2 && guard < 300) begin step(0, 0, 1, 1); guard++; end
        check("p3_blocks_done", 64'(blocks_done1), 64'd2);
        check("p3_wr_ready_after_release", 64'(wr_ready1), 64'd1);

        // Read side throttled every other cycle
        step(0, 1, 0, 0);
        track_reset();
        for (int i = 0; i < BB; i++) step(0, 0, 1, 0);
        guard = 0;
        while (blocks_done1 != 16'd1 && guard < 600) begin step(0, 0, 0, guard[0]); guard++; end
        check("p4_blocks_done", 64'(blocks_done1), 64'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        check("p4_beats_lat1", 64'(beats1), 64'd102);
        check("p4_beats_lat2", 64'(beats2), 64'd102);

        // Bank 1 write completes on the same edge bank 0 stream ends
        step(0, 1, 0, 0);
        for (int i = 0; i < BB; i++) step(0, 0, 1, 1);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1);
        for (int i = 0; i < BB - 1; i++) step(0, 0, 1, 1);
        check("p5_bank_full_before", 64'(bank_full1), 64'd1);
        step(0, 0, 1, 1);
        check("p5_bank_full_after", 64'(bank_full1), 64'd2);
        step(0, 0, 0, 1);
        check("p5_rd_en", 64'(rd_en1), 64'd1);
        check("p5_rd_addr", 64'(rd_addr1), 64'd186);

        // Flush with both banks full, mid-preload
        step(0, 1, 0, 0);
        for (int i = 0; i < 2 * BB; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        check("p6_bank_full", 64'(bank_full1), 64'd0);
        check("p6_q_valid_lat1", 64'(q_valid1), 64'd0);
        check("p6_q_valid_lat2", 64'(q_valid2), 64'd0);
        check("p6_rd_addr", 64'(rd_addr1), 64'd0);
        check("p6_blocks_done", 64'(blocks_done1), 64'd0);
        step(0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(0, 799) == 0);
            fl = ($urandom_range(0, 499) == 0);
            wv = ($urandom_range(0, 3) != 0) && !rs;
            rr = ($urandom_range(0, 1) == 1);
            step(rs, fl, wv, rr);
        end
        step(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
